bcd_count_scheduler: RTL and testbench
======================================

// Module: bcd_count_scheduler
// PURPOSE
//  Control and sequencing block for the two-digit BCD display counter. Takes one-cycle request
//  pulses from the debounced push-button edge detectors, resolves simultaneous requests by fixed
//  priority and runs a RUN/PAUSE/LOAD state machine. Generates its own step tick and owns the
//  00-99 BCD count that drives the seven-segment converters.
// PARAMETERS
//  TICK_DIV  50_000_000  CLOCK_50_I cycles per count step (1 Hz on board; 4 in simulation)
// PORTS
//  CLOCK_50_I        in   1  50 MHz clock; all flops on posedge
//  resetn            in   1  asynchronous, active-low reset
//  req_start_stop_i  in   1  one-cycle pulse: toggle run/pause
//  req_up_i          in   1  one-cycle pulse: select count up
//  req_down_i        in   1  one-cycle pulse: select count down
//  req_load_i        in   1  one-cycle pulse: load load_value_i
//  load_value_i      in   8  BCD preset {tens,units}, sampled on accepted load
//  count_o           out  8  current BCD count {tens,units}
//  state_o           out  2  encoded FSM state (package enum)
//  running_o         out  1  1 while state is RUN
//  dir_up_o          out  1  1 = count up, 0 = count down
//  tick_o            out  1  one-cycle pulse on each applied count step
//  load_err_o        out  1  one-cycle pulse on rejected (non-BCD) load
// BEHAVIOUR
//  Reset: state IDLE, count_o 8'h00, dir_up_o 1, running_o/tick_o/load_err_o 0, divider 0.
//  Priority per cycle: load > start_stop > down > up; one request accepted, the rest dropped.
//  FSM: IDLE -start_stop-> RUN; RUN -start_stop-> PAUSE; PAUSE -start_stop-> RUN.
//   Valid load in any state -> LOAD (1 cycle, count_o <= load_value_i) -> PAUSE.
//   Invalid load (either nibble > 9): state and count unchanged, load_err_o pulses next cycle.
//   Requests arriving while in LOAD are dropped.
//  Direction: up/down requests set dir_up_o in IDLE/RUN/PAUSE; state unchanged.
//  Divider: counts 0..TICK_DIV-1 only in RUN, held at 0 otherwise; first step comes TICK_DIV
//   cycles after entering RUN. Terminal value -> step: tick_o pulses registered, count updates.
//  Step uses dir_up_o value registered before the current cycle; a direction request in the
//   same cycle affects the next step only. start_stop in the same cycle as terminal divider:
//   step still applied, then PAUSE. Load in the same cycle: load wins, no step, no tick_o.
//  Arithmetic: units 0-9 with carry/borrow into tens; up 99 -> 00, down 00 -> 99.
//  Count never leaves valid BCD; all outputs registered (1-cycle latency from request).
//  Reset asserted mid-run: immediate return to reset values regardless of state.
// CONFIGURATION
//  AUTO_REVERSE_EN defined: at a boundary step the count bounces instead of wrapping;
//   up at 99 -> 98 with dir_up_o <= 0; down at 00 -> 01 with dir_up_o <= 1.
//  AUTO_REVERSE_EN undefined: plain wrap 99 -> 00 / 00 -> 99, dir_up_o changes only by request.
// STRUCTURE
//  Package bcd_sched_pkg: typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LOAD};
//   BCD_MAX = 4'd9; typedef for 8-bit BCD pair.
//  Sub-module bcd_digit: one 4-bit BCD digit, inputs inc/dec/load, outputs value, carry
//   (9 -> 0 on inc), borrow (0 -> 9 on dec); instantiated twice (units, tens chained).
//  Top: request priority encoder, FSM, divider, direction register, output registers.
// TESTING (TICK_DIV = 4)
//  Reset, start_stop, 12 cycles idle -> RUN; tick_o at cycles 4,8,12; count_o 01,02,03.
//  Load 8'h98, start, wait 3 ticks -> count_o 99, 00, 01; tens carry correct.
//  Down request, count 8'h01, 2 ticks -> 00 then 99 (macro off) or 01 with dir_up_o=1 (on).
//  Load 8'h3A -> load_err_o one cycle, count_o and state_o unchanged.
//  load + start_stop + up same cycle in RUN -> load taken, LOAD then PAUSE, dir unchanged.
//  resetn low in RUN at count 8'h57 -> count_o 00, state IDLE, dir_up_o 1 same cycle.

Source files
------------

// File: rtl/bcd_sched_pkg.sv
// Shared types for the two-digit BCD counter scheduler.
// FSM state encoding, BCD pair type and a digit-validity helper.
package bcd_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE,
      S_LOAD
   } sched_state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;

   typedef logic [7:0] bcd_pair_t;

   function automatic logic is_bcd(input bcd_pair_t v);
      return (v[7:4] <= BCD_MAX) && (v[3:0] <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_count_scheduler_if.sv
// Request/status bundle between the button front end and the scheduler.
// master drives requests, slave (the scheduler) drives count and status.
interface bcd_count_scheduler_if;
   import bcd_sched_pkg::*;

   logic         req_start_stop_i;
   logic         req_up_i;
   logic         req_down_i;
   logic         req_load_i;
   bcd_pair_t    load_value_i;
   bcd_pair_t    count_o;
   sched_state_e state_o;
   logic         running_o;
   logic         dir_up_o;
   logic         tick_o;
   logic         load_err_o;

   modport master (
      output req_start_stop_i, req_up_i,
      output req_down_i, req_load_i,
      output load_value_i,
      input  count_o, state_o, running_o,
      input  dir_up_o, tick_o, load_err_o
   );

   modport slave (
      input  req_start_stop_i, req_up_i,
      input  req_down_i, req_load_i,
      input  load_value_i,
      output count_o, state_o, running_o,
      output dir_up_o, tick_o, load_err_o
   );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit 0-9 with load, wrap-around inc/dec and carry/borrow out.
// Load has priority over inc/dec; carry/borrow depend only on inc/dec.
module bcd_digit
   import bcd_sched_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       inc,
   input  logic       dec,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic [3:0] value,
   output logic       carry,
   output logic       borrow
);

   assign carry  = inc && (value == BCD_MAX);
   assign borrow = dec && (value == 4'd0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         value <= 4'd0;
      end else if (load) begin
         value <= load_val;
      end else if (inc) begin
         value <= carry ? 4'd0 : value + 4'd1;
      end else if (dec) begin
         value <= borrow ? BCD_MAX : value - 4'd1;
      end
   end

endmodule

// File: rtl/bcd_count_scheduler.sv
// Run/pause/load scheduler with step divider and 00-99 BCD count.
// Define AUTO_REVERSE_EN to bounce at 99/00 instead of wrapping.
module bcd_count_scheduler
   import bcd_sched_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input logic                  CLOCK_50_I,
   input logic                  resetn,
   bcd_count_scheduler_if.slave bus
);

   localparam int unsigned DIV_W =
      (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST =
      DIV_W'(TICK_DIV - 1);

   sched_state_e     state_q, state_d;
   logic             dir_q, dir_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_q, err_q;
   logic             sel_load, sel_ss;
   logic             sel_dn, sel_up;
   logic             terminal, step;
   logic             inc, dec;
   logic             ld, bad_load;
   bcd_pair_t        ld_val;
   logic [3:0]       units_v, tens_v;
   logic             u_carry, u_borrow;
   logic             t_carry, t_borrow;

   // LOAD swallows every request; otherwise one-hot by priority
   assign sel_load = bus.req_load_i && (state_q != S_LOAD);
   assign sel_ss   = bus.req_start_stop_i && (state_q != S_LOAD)
                     && !bus.req_load_i;
   assign sel_dn   = bus.req_down_i && (state_q != S_LOAD)
                     && !bus.req_load_i && !bus.req_start_stop_i;
   assign sel_up   = bus.req_up_i && (state_q != S_LOAD)
                     && !bus.req_load_i && !bus.req_start_stop_i
                     && !bus.req_down_i;

   assign terminal = (state_q == S_RUN) && (div_q == DIV_LAST);
   assign step     = terminal && !bus.req_load_i;
   assign inc      = step && dir_q;
   assign dec      = step && !dir_q;

   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      ld       = 1'b0;
      ld_val   = bus.load_value_i;
      bad_load = 1'b0;
`ifdef AUTO_REVERSE_EN
      if (t_carry) begin
         ld     = 1'b1;
         ld_val = 8'h98;
         dir_d  = 1'b0;
      end else if (t_borrow) begin
         ld     = 1'b1;
         ld_val = 8'h01;
         dir_d  = 1'b1;
      end
`endif
      if (state_q == S_LOAD) state_d = S_PAUSE;
      unique case (1'b1)
         sel_load: begin
            if (is_bcd(bus.load_value_i)) begin
               state_d = S_LOAD;
               ld      = 1'b1;
               ld_val  = bus.load_value_i;
            end else begin
               bad_load = 1'b1;
            end
         end
         sel_ss: state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
         sel_dn: dir_d = 1'b0;
         sel_up: dir_d = 1'b1;
         default: ;
      endcase
      div_d = (state_q == S_RUN && state_d == S_RUN && !terminal)
              ? div_q + 1'b1 : '0;
   end

`ifndef AUTO_REVERSE_EN
   logic unused_tens_wrap;
   assign unused_tens_wrap = t_carry ^ t_borrow;
`endif

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         dir_q   <= 1'b1;
         div_q   <= '0;
         tick_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         div_q   <= div_d;
         tick_q  <= step;
         err_q   <= bad_load;
      end
   end

   bcd_digit u_units (
      .clk      (CLOCK_50_I),
      .resetn   (resetn),
      .inc      (inc),
      .dec      (dec),
      .load     (ld),
      .load_val (ld_val[3:0]),
      .value    (units_v),
      .carry    (u_carry),
      .borrow   (u_borrow)
   );

   bcd_digit u_tens (
      .clk      (CLOCK_50_I),
      .resetn   (resetn),
      .inc      (u_carry),
      .dec      (u_borrow),
      .load     (ld),
      .load_val (ld_val[7:4]),
      .value    (tens_v),
      .carry    (t_carry),
      .borrow   (t_borrow)
   );

   assign bus.count_o    = {tens_v, units_v};
   assign bus.state_o    = state_q;
   assign bus.running_o  = (state_q == S_RUN);
   assign bus.dir_up_o   = dir_q;
   assign bus.tick_o     = tick_q;
   assign bus.load_err_o = err_q;

endmodule

// File: tb/tb_bcd_count_scheduler.sv
// Self-checking bench: directed scenarios plus random requests
// compared each cycle against an integer-arithmetic reference model.
module tb_bcd_count_scheduler;
   import bcd_sched_pkg::*;

   localparam int TD = 4;

   logic CLOCK_50_I = 1'b0;
   logic resetn = 1'b0;
   always #5 CLOCK_50_I = ~CLOCK_50_I;

   bcd_count_scheduler_if bus();

   bcd_count_scheduler #(.TICK_DIV(TD)) dut (
      .CLOCK_50_I (CLOCK_50_I),
      .resetn     (resetn),
      .bus        (bus)
   );

   int checks = 0;
   int errors = 0;

   // reference model: count as integer 0..99, cycles spent in RUN
   int           m_count, m_cyc;
   logic         m_dir, m_tick, m_err;
   sched_state_e m_state;

   function automatic logic [7:0] to_bcd(input int c);
      return {4'(c / 10), 4'(c % 10)};
   endfunction

   task automatic model_reset();
      m_count = 0; m_cyc = 0; m_dir = 1'b1;
      m_tick = 1'b0; m_err = 1'b0; m_state = S_IDLE;
   endtask

   task automatic model_clk(input logic ss, up, dn, ld,
                            input logic [7:0] v);
      sched_state_e ns;
      logic nd;
      ns = m_state; nd = m_dir;
      m_tick = 1'b0; m_err = 1'b0;
      if (m_state == S_LOAD) begin
         ns = S_PAUSE;
      end else begin
         if (m_state == S_RUN && m_cyc == TD - 1 && !ld) begin
            m_tick = 1'b1;
            if (m_dir) begin
`ifdef AUTO_REVERSE_EN
               if (m_count == 99) begin m_count = 98; nd = 1'b0; end
               else m_count = m_count + 1;
`else
               m_count = (m_count + 1) % 100;
`endif
            end else begin
`ifdef AUTO_REVERSE_EN
               if (m_count == 0) begin m_count = 1; nd = 1'b1; end
               else m_count = m_count - 1;
`else
               m_count = (m_count + 99) % 100;
`endif
            end
         end
         if (ld) begin
            if (int'(v[7:4]) <= 9 && int'(v[3:0]) <= 9) begin
               ns = S_LOAD;
               m_count = int'(v[7:4]) * 10 + int'(v[3:0]);
            end else m_err = 1'b1;
         end else if (ss) ns = (m_state == S_RUN) ? S_PAUSE : S_RUN;
         else if (dn) nd = 1'b0;
         else if (up) nd = 1'b1;
      end
      m_cyc = (m_state == S_RUN && ns == S_RUN) ? (m_cyc + 1) % TD : 0;
      m_state = ns; m_dir = nd;
   endtask

   // call at posedge+1; returns at next posedge+1
   task automatic cycle(input logic ss, up, dn, ld,
                        input logic [7:0] v);
      bus.req_start_stop_i = ss;
      bus.req_up_i = up;
      bus.req_down_i = dn;
      bus.req_load_i = ld;
      bus.load_value_i = v;
      @(posedge CLOCK_50_I);
      model_clk(ss, up, dn, ld, v);
      #1;
      bus.req_start_stop_i = 1'b0;
      bus.req_up_i = 1'b0;
      bus.req_down_i = 1'b0;
      bus.req_load_i = 1'b0;
   endtask

   task automatic test_reset();
      bus.req_start_stop_i = 1'b0; bus.req_up_i = 1'b0;
      bus.req_down_i = 1'b0; bus.req_load_i = 1'b0;
      bus.load_value_i = 8'h00;
      resetn = 1'b0;
      model_reset();
      repeat (3) @(posedge CLOCK_50_I);
      #1;
      checks++;
      if (bus.count_o !== 8'h00) begin errors++;
         $display("FAIL reset count: got %h want 00", bus.count_o); end
      checks++;
      if (bus.state_o !== S_IDLE) begin errors++;
         $display("FAIL reset state: got %0d want %0d", bus.state_o, S_IDLE); end
      checks++;
      if (bus.dir_up_o !== 1'b1) begin errors++;
         $display("FAIL reset dir: got %b want 1", bus.dir_up_o); end
      checks++;
      if (bus.running_o !== 1'b0) begin errors++;
         $display("FAIL reset running: got %b want 0", bus.running_o); end
      checks++;
      if (bus.tick_o !== 1'b0) begin errors++;
         $display("FAIL reset tick: got %b want 0", bus.tick_o); end
      checks++;
      if (bus.load_err_o !== 1'b0) begin errors++;
         $display("FAIL reset err: got %b want 0", bus.load_err_o); end
      resetn = 1'b1;
   endtask

   task automatic test_count_up();
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.state_o !== S_RUN || bus.running_o !== 1'b1) begin errors++;
         $display("FAIL start: state %0d run %b want %0d 1",
                  bus.state_o, bus.running_o, S_RUN); end
      for (int i = 1; i <= 12; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         checks++;
         if (bus.tick_o !== 1'((i % 4) == 0) || bus.count_o !== to_bcd(i / 4)) begin
            errors++;
            $display("FAIL count_up c%0d: tick %b count %h want %b %h",
                     i, bus.tick_o, bus.count_o, 1'((i % 4) == 0), to_bcd(i / 4));
         end
      end
   endtask

   task automatic test_carry();
      logic [7:0] exp_c [3];
      exp_c[0] = 8'h99; exp_c[1] = 8'h00; exp_c[2] = 8'h01;
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.state_o !== S_PAUSE) begin errors++;
         $display("FAIL pause: state %0d want %0d", bus.state_o, S_PAUSE); end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h98);
      checks++;
      if (bus.state_o !== S_LOAD || bus.count_o !== 8'h98) begin errors++;
         $display("FAIL load98: state %0d count %h want %0d 98",
                  bus.state_o, bus.count_o, S_LOAD); end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.state_o !== S_PAUSE) begin errors++;
         $display("FAIL load->pause: state %0d want %0d", bus.state_o, S_PAUSE); end
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 1; i <= 12; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         if (i % 4 == 0) begin
            checks++;
            if (bus.tick_o !== 1'b1 || bus.count_o !== exp_c[i/4-1]) begin
               errors++;
               $display("FAIL carry step%0d: tick %b count %h want 1 %h",
                        i / 4, bus.tick_o, bus.count_o, exp_c[i/4-1]);
            end
         end
      end
   endtask

   task automatic test_down_wrap();
      int ticks;
      logic [7:0] want;
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if (bus.dir_up_o !== 1'b0 || bus.count_o !== 8'h01) begin errors++;
         $display("FAIL down req: dir %b count %h want 0 01",
                  bus.dir_up_o, bus.count_o); end
      ticks = 0;
      for (int i = 0; i < 20 && ticks < 2; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         if (bus.tick_o === 1'b1) begin
            ticks++;
`ifdef AUTO_REVERSE_EN
            want = (ticks == 1) ? 8'h00 : 8'h01;
`else
            want = (ticks == 1) ? 8'h00 : 8'h99;
`endif
            checks++;
            if (bus.count_o !== want) begin errors++;
               $display("FAIL down step%0d: count %h want %h",
                        ticks, bus.count_o, want); end
         end
      end
      checks++;
      if (ticks != 2) begin errors++;
         $display("FAIL down timeout: ticks %0d want 2", ticks); end
`ifdef AUTO_REVERSE_EN
      checks++;
      if (bus.dir_up_o !== 1'b1) begin errors++;
         $display("FAIL bounce dir: got %b want 1", bus.dir_up_o); end
`endif
   endtask

   task automatic test_bad_load();
      logic [7:0] snap;
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      snap = to_bcd(m_count);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h3A);
      checks++;
      if (bus.load_err_o !== 1'b1 || bus.count_o !== snap ||
          bus.state_o !== S_PAUSE) begin errors++;
         $display("FAIL bad_load: err %b count %h state %0d want 1 %h %0d",
                  bus.load_err_o, bus.count_o, bus.state_o, snap, S_PAUSE); end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.load_err_o !== 1'b0) begin errors++;
         $display("FAIL bad_load pulse: err %b want 0", bus.load_err_o); end
   endtask

   task automatic test_priority();
      logic d0;
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      d0 = m_dir;
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h42);
      checks++;
      if (bus.state_o !== S_LOAD || bus.count_o !== 8'h42 ||
          bus.dir_up_o !== d0) begin errors++;
         $display("FAIL priority: state %0d count %h dir %b want %0d 42 %b",
                  bus.state_o, bus.count_o, bus.dir_up_o, S_LOAD, d0); end
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.state_o !== S_PAUSE || bus.running_o !== 1'b0) begin errors++;
         $display("FAIL priority exit: state %0d run %b want %0d 0",
                  bus.state_o, bus.running_o, S_PAUSE); end
   endtask

   task automatic test_reset_midrun();
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h57);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if (bus.count_o !== 8'h57 || bus.state_o !== S_RUN) begin errors++;
         $display("FAIL pre-reset: count %h state %0d want 57 %0d",
                  bus.count_o, bus.state_o, S_RUN); end
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (bus.count_o !== 8'h00 || bus.state_o !== S_IDLE ||
          bus.dir_up_o !== 1'b1 || bus.running_o !== 1'b0) begin errors++;
         $display("FAIL async reset: count %h state %0d dir %b run %b want 00 %0d 1 0",
                  bus.count_o, bus.state_o, bus.dir_up_o, bus.running_o, S_IDLE); end
      model_reset();
      @(posedge CLOCK_50_I);
      #1 resetn = 1'b1;
   endtask

   task automatic test_random();
      logic ss, up, dn, ld;
      logic [7:0] v;
      for (int i = 0; i < 600; i++) begin
         ss = ($urandom_range(0, 7) == 0);
         up = ($urandom_range(0, 5) == 0);
         dn = ($urandom_range(0, 5) == 0);
         ld = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 1) == 0)
            v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         else
            v = 8'($urandom);
         cycle(ss, up, dn, ld, v);
         checks++;
         if (bus.count_o !== to_bcd(m_count) || bus.state_o !== m_state ||
             bus.dir_up_o !== m_dir || bus.running_o !== (m_state == S_RUN) ||
             bus.tick_o !== m_tick || bus.load_err_o !== m_err) begin
            errors++;
            $display("FAIL random c%0d: cnt %h st %0d dir %b run %b tick %b err %b want %h %0d %b %b %b %b",
                     i, bus.count_o, bus.state_o, bus.dir_up_o, bus.running_o,
                     bus.tick_o, bus.load_err_o, to_bcd(m_count), m_state,
                     m_dir, (m_state == S_RUN), m_tick, m_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_carry();
      test_down_wrap();
      test_bad_load();
      test_priority();
      test_reset_midrun();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
